mdu_sequencer: RTL and testbench

- Multi-cycle controller for the RV32M multiply/divide ops in the EX stage.
- Accepts one M-extension op at a time from ID/EX and sequences an iterative 32-step shift-add multiplier or restoring divider.
- Raises BUSY to stall the pipeline and returns a 32-bit RESULT with a one-cycle VALID pulse.
- Sits beside alu; EX result mux selects RESULT when VALID is high.

---
 rtl/mdu_sequencer.sv | 162 ++++++++++++++++
 tb/tb_mdu_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// RV32M multiply/divide sequencer: iterative 32-step shift-add multiplier and restoring divider.
// Define MDU_FAST_MUL_EN to replace the iterative multiply with a single-cycle multiplier in PREP.
module mdu_sequencer #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ITER = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic            KILL,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  input  logic [4:0]      SELECT,
  output logic            BUSY,
  output logic            VALID,
  output logic [XLEN-1:0] RESULT
);

  localparam int unsigned CW = $clog2(ITER);

  typedef enum logic [2:0] {
    S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_e;

  state_e            state_q;
  op_e               op_q;
  logic [XLEN-1:0]   a_q, b_q, result_q;
  logic [2*XLEN-1:0] prod_q;
  logic [CW-1:0]     cnt_q;
  logic              neg_a_q, neg_b_q, valid_q;

  logic              accept;
  op_e               sel_op;
  logic              neg_a_d, neg_b_d;
  logic              is_div, div0, ovf;
  logic [XLEN-1:0]   abs_a, abs_b, special_d, fix_d;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN+1:0]   div_diff;
  logic              div_ok;
  logic [2*XLEN-1:0] calc_d, prod_neg;
  logic [XLEN-1:0]   quo, rem;
  logic              unused_sel;

  // SELECT[3] is always zero for M-ops; only bit 4 qualifies a request
  assign unused_sel = SELECT[3];
  assign sel_op     = op_e'(SELECT[2:0]);
  assign accept     = START && SELECT[4] && !KILL;
  assign neg_a_d    = DATA1[XLEN-1] && (sel_op == OP_MULH || sel_op == OP_MULHSU ||
                                        sel_op == OP_DIV  || sel_op == OP_REM);
  assign neg_b_d    = DATA2[XLEN-1] && (sel_op == OP_MULH || sel_op == OP_DIV ||
                                        sel_op == OP_REM);

  always_comb begin
    is_div    = op_q[2];
    abs_a     = neg_a_q ? -a_q : a_q;
    abs_b     = neg_b_q ? -b_q : b_q;
    div0      = is_div && (b_q == '0);
    ovf       = (op_q == OP_DIV || op_q == OP_REM) &&
                (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
    // op_q[1] separates REM/REMU from DIV/DIVU
    if (div0) special_d = op_q[1] ? a_q : '1;
    else      special_d = op_q[1] ? '0  : a_q;

    mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, a_q} : '0);
    div_shift = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, b_q};
    div_ok    = !div_diff[XLEN+1];
    if (is_div)
      calc_d = {(div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                prod_q[XLEN-2:0], div_ok};
    else
      calc_d = {mul_sum, prod_q[XLEN-1:1]};

    prod_neg  = -prod_q;
    quo       = (neg_a_q ^ neg_b_q) ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
    rem       = neg_a_q ? -prod_q[2*XLEN-1:XLEN] : prod_q[2*XLEN-1:XLEN];
    if (is_div)
      fix_d = op_q[1] ? rem : quo;
    else if (op_q == OP_MUL)
      fix_d = prod_q[XLEN-1:0];
    else
      fix_d = (neg_a_q ^ neg_b_q) ? prod_neg[2*XLEN-1:XLEN] : prod_q[2*XLEN-1:XLEN];
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MUL;
      a_q      <= '0;
      b_q      <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      valid_q <= 1'b0;
      if (KILL && state_q != S_IDLE) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: if (accept) begin
            op_q    <= sel_op;
            a_q     <= DATA1;
            b_q     <= DATA2;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            state_q <= S_PREP;
          end
          S_PREP: begin
            if (div0 || ovf) begin
              result_q <= special_d;
              valid_q  <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              a_q   <= abs_a;
              b_q   <= abs_b;
              cnt_q <= CW'(ITER - 1);
`ifdef MDU_FAST_MUL_EN
              if (!is_div) begin
                prod_q  <= {{XLEN{1'b0}}, abs_a} * {{XLEN{1'b0}}, abs_b};
                state_q <= S_FIX;
              end else begin
                prod_q  <= {{XLEN{1'b0}}, abs_a};
                state_q <= S_CALC;
              end
`else
              // Dividend or multiplier starts in the low half and shifts out as CALC runs
              prod_q  <= {{XLEN{1'b0}}, (is_div ? abs_a : abs_b)};
              state_q <= S_CALC;
`endif
            end
          end
          S_CALC: begin
            prod_q <= calc_d;
            cnt_q  <= cnt_q - CW'(1);
            if (cnt_q == '0) state_q <= S_FIX;
          end
          S_FIX: begin
            result_q <= fix_d;
            valid_q  <= 1'b1;
            state_q  <= S_DONE;
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign BUSY   = (state_q == S_IDLE && accept) || state_q == S_PREP ||
                  state_q == S_CALC || state_q == S_FIX;
  assign VALID  = valid_q;
  assign RESULT = result_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: directed RV32M cases, special divides, KILL, reset and random ops.
module tb_mdu_sequencer;

`ifdef MDU_FAST_MUL_EN
  localparam int unsigned LAT_MUL = 3;
`else
  localparam int unsigned LAT_MUL = 35;
`endif
  localparam int unsigned LAT_DIV = 35;
  localparam int unsigned LAT_SPC = 2;

  logic        CLK, RESET, START, KILL;
  logic [31:0] DATA1, DATA2, RESULT;
  logic [4:0]  SELECT;
  logic        BUSY, VALID;

  typedef struct {
    logic [31:0] res;
    int unsigned lat;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] last_res = '0;

  mdu_sequencer #(.XLEN(32), .ITER(32)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .KILL(KILL),
    .DATA1(DATA1), .DATA2(DATA2), .SELECT(SELECT),
    .BUSY(BUSY), .VALID(VALID), .RESULT(RESULT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [4:0] sel, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] p;
    logic [63:0]        pu;
    logic               sovf;
    sovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (sel[2:0])
      3'd0: begin pu = {32'b0, a} * {32'b0, b}; return pu[31:0]; end
      3'd1: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
      3'd2: begin p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return p[63:32]; end
      3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (sovf) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (sovf) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int unsigned ref_lat(input logic [4:0] sel, input logic [31:0] a,
                                          input logic [31:0] b);
    if (!sel[2]) return LAT_MUL;
    if (b == 0) return LAT_SPC;
    if (!sel[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return LAT_SPC;
    return LAT_DIV;
  endfunction

  // Drives one op in cycle 0, then follows it to its VALID pulse.
  task automatic run_op(input string tag, input logic [4:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int unsigned lat);
    exp_t e;
    bit   seen;
    @(negedge CLK);
    START = 1'b1; SELECT = sel; DATA1 = a; DATA2 = b;
    #1 check_eq({tag, "_busy_c0"}, {31'b0, BUSY}, 32'd1);
    sb_q.push_back('{res: exp, lat: lat});
    seen = 1'b0;
    for (int unsigned k = 1; k <= 100 && !seen; k++) begin
      @(negedge CLK);
      if (k == 1) begin
        START = 1'b0; DATA1 = $urandom; DATA2 = $urandom;
      end
      if (VALID) begin
        seen = 1'b1;
        e = sb_q.pop_front();
        check_eq({tag, "_result"}, RESULT, e.res);
        check_eq({tag, "_latency"}, k, e.lat);
        check_eq({tag, "_busy_done"}, {31'b0, BUSY}, 32'd0);
        last_res = e.res;
      end else if (k < sb_q[0].lat) begin
        if (BUSY !== 1'b1) check_eq({tag, "_busy"}, {31'b0, BUSY}, 32'd1);
      end
    end
    if (!seen) begin
      check_eq({tag, "_timeout"}, 32'd0, 32'd1);
      void'(sb_q.pop_front());
    end
    @(negedge CLK);
    check_eq({tag, "_valid_pulse"}, {31'b0, VALID}, 32'd0);
    check_eq({tag, "_result_hold"}, RESULT, last_res);
  endtask

  task automatic expect_quiet(input string tag, input int unsigned cycles);
    int unsigned stray = 0;
    for (int unsigned k = 0; k < cycles; k++) begin
      @(negedge CLK);
      if (VALID) stray++;
    end
    check_eq({tag, "_no_valid"}, stray, 32'd0);
  endtask

  initial begin
    logic [4:0]  s;
    logic [31:0] a, b;
    RESET = 1'b0; START = 1'b0; KILL = 1'b0;
    DATA1 = '0; DATA2 = '0; SELECT = '0;
    #1;
    check_eq("rst_busy", {31'b0, BUSY}, 32'd0);
    check_eq("rst_valid", {31'b0, VALID}, 32'd0);
    check_eq("rst_result", RESULT, 32'd0);
    @(negedge CLK); @(negedge CLK);
    RESET = 1'b1;

    run_op("mul",    5'b10000, 32'd7,          32'd6,          32'd42,         LAT_MUL);
    run_op("mulh",   5'b10001, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          LAT_MUL);
    run_op("mulhu",  5'b10011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  LAT_MUL);
    run_op("mulhsu", 5'b10010, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  LAT_MUL);
    run_op("div",    5'b10100, 32'hFFFF_FFEC,  32'd3,          32'hFFFF_FFFA,  LAT_DIV);
    run_op("rem",    5'b10110, 32'hFFFF_FFEC,  32'd3,          32'hFFFF_FFFE,  LAT_DIV);
    run_op("divu",   5'b10101, 32'd100,        32'd7,          32'd14,         LAT_DIV);
    run_op("remu",   5'b10111, 32'd100,        32'd7,          32'd2,          LAT_DIV);
    run_op("divu0",  5'b10101, 32'd123,        32'd0,          32'hFFFF_FFFF,  LAT_SPC);
    run_op("remu0",  5'b10111, 32'd123,        32'd0,          32'd123,        LAT_SPC);
    run_op("rem0",   5'b10110, 32'hFFFF_FFEC,  32'd0,          32'hFFFF_FFEC,  LAT_SPC);
    run_op("divovf", 5'b10100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  LAT_SPC);
    run_op("removf", 5'b10110, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          LAT_SPC);

    // KILL in cycle 10 of a DIVU
    run_op("pre_kill", 5'b10000, 32'd11, 32'd13, 32'd143, LAT_MUL);
    @(negedge CLK);
    START = 1'b1; SELECT = 5'b10101; DATA1 = 32'd100; DATA2 = 32'd7;
    for (int unsigned k = 1; k <= 10; k++) begin
      @(negedge CLK);
      if (k == 1) START = 1'b0;
      if (k == 10) KILL = 1'b1;
    end
    @(negedge CLK);
    KILL = 1'b0;
    check_eq("kill_busy", {31'b0, BUSY}, 32'd0);
    check_eq("kill_valid", {31'b0, VALID}, 32'd0);
    check_eq("kill_result", RESULT, 32'd143);
    expect_quiet("kill", 40);
    run_op("post_kill", 5'b10000, 32'd3, 32'd5, 32'd15, LAT_MUL);

    // Non-M op is ignored
    @(negedge CLK);
    START = 1'b1; SELECT = 5'b00000; DATA1 = 32'd1; DATA2 = 32'd2;
    #1 check_eq("add_busy", {31'b0, BUSY}, 32'd0);
    @(negedge CLK);
    START = 1'b0;
    check_eq("add_busy_next", {31'b0, BUSY}, 32'd0);
    expect_quiet("add", 40);

    // Asynchronous reset mid-CALC
    @(negedge CLK);
    START = 1'b1; SELECT = 5'b10100; DATA1 = 32'd1000; DATA2 = 32'd9;
    for (int unsigned k = 1; k <= 10; k++) begin
      @(negedge CLK);
      if (k == 1) START = 1'b0;
    end
    #2 RESET = 1'b0;
    #1;
    check_eq("arst_busy", {31'b0, BUSY}, 32'd0);
    check_eq("arst_valid", {31'b0, VALID}, 32'd0);
    check_eq("arst_result", RESULT, 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    expect_quiet("arst", 40);

    for (int unsigned i = 0; i < 10; i++) begin
      s = {2'b10, 3'($urandom_range(0, 7))};
      a = $urandom;
      b = (i % 4 == 3) ? 32'd0 : $urandom;
      if (i % 5 == 1) b = 32'($urandom_range(1, 15));
      run_op("rand", s, a, b, ref_model(s, a, b), ref_lat(s, a, b));
    end

    check_eq("sb_empty", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
